wb_retire_stage: RTL and testbench

//  Parametrised write-back/retire stage between MEM stage and the register file.

---
 rtl/wb_retire_stage.sv | 142 ++++++++++++++
 tb/tb_wb_retire_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_stage.sv
// Write-back/retire stage: in-order retire queue between MEM and the register file,
// with precise exception flush, age-ordered bypass outputs and debug trace.
module wb_retire_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EXC_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid_i,
    output logic                       ws_allowin_o,
    input  logic                       ms_gr_we_i,
    input  logic [RF_AW-1:0]           ms_dest_i,
    input  logic [XLEN-1:0]            ms_result_i,
    input  logic [XLEN-1:0]            ms_pc_i,
    input  logic                       ms_exc_i,
    input  logic [EXC_W-1:0]           ms_exc_code_i,
    input  logic                       rf_ready_i,
    output logic                       rf_we_o,
    output logic [RF_AW-1:0]           rf_waddr_o,
    output logic [XLEN-1:0]            rf_wdata_o,
    output logic                       ws_flush_o,
    output logic [XLEN-1:0]            ws_epc_o,
    output logic [EXC_W-1:0]           ws_exc_code_o,
    output logic [DEPTH-1:0]           ws_fwd_valid_o,
    output logic [DEPTH*RF_AW-1:0]     ws_fwd_dest_o,
    output logic [DEPTH*XLEN-1:0]      ws_fwd_data_o,
    output logic [$clog2(DEPTH):0]     ws_count_o,
    output logic [XLEN-1:0]            debug_wb_pc_o,
    output logic [3:0]                 debug_wb_rf_we_o,
    output logic [RF_AW-1:0]           debug_wb_rf_wnum_o,
    output logic [XLEN-1:0]            debug_wb_rf_wdata_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic             gr_we_q    [DEPTH];
    logic [RF_AW-1:0] dest_q     [DEPTH];
    logic [XLEN-1:0]  result_q   [DEPTH];
    logic [XLEN-1:0]  pc_q       [DEPTH];
    logic             exc_q      [DEPTH];
    logic [EXC_W-1:0] exc_code_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic             empty;
    logic             h_gr_we;
    logic [RF_AW-1:0] h_dest;
    logic [XLEN-1:0]  h_result;
    logic [XLEN-1:0]  h_pc;
    logic             h_exc;
    logic [EXC_W-1:0] h_exc_code;
    logic             flush;
    logic             pop;
    logic             accept;
    logic             allowin;

    assign empty      = (count_q == '0);
    assign h_gr_we    = gr_we_q[head_q];
    assign h_dest     = dest_q[head_q];
    assign h_result   = result_q[head_q];
    assign h_pc       = pc_q[head_q];
    assign h_exc      = exc_q[head_q];
    assign h_exc_code = exc_code_q[head_q];

    // Depends on registered count only, so rf_ready never reaches upstream handshake.
    assign allowin = (count_q < CW'(DEPTH));
    assign flush   = !empty && h_exc;
    assign pop     = !empty && (h_exc || !h_gr_we || (h_dest == '0) || rf_ready_i);
    assign accept  = ms_to_ws_valid_i && allowin && !flush;

    assign ws_allowin_o        = allowin;
    assign ws_flush_o          = flush;
    assign ws_epc_o            = flush ? h_pc : '0;
    assign ws_exc_code_o       = flush ? h_exc_code : '0;
    assign rf_we_o             = !empty && h_gr_we && (h_dest != '0) && !h_exc;
    assign rf_waddr_o          = empty ? '0 : h_dest;
    assign rf_wdata_o          = empty ? '0 : h_result;
    assign ws_count_o          = count_q;
    assign debug_wb_pc_o       = empty ? '0 : h_pc;
    assign debug_wb_rf_we_o    = {4{rf_we_o & rf_ready_i}};
    assign debug_wb_rf_wnum_o  = rf_waddr_o;
    assign debug_wb_rf_wdata_o = rf_wdata_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) head_d = head_q + PW'(1);
            if (accept) tail_d = tail_q + PW'(1);
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    // Bypass view ordered by age: slot 0 is always the head.
    always_comb begin
        logic [PW-1:0] slot;
        slot           = '0;
        ws_fwd_valid_o = '0;
        ws_fwd_dest_o  = '0;
        ws_fwd_data_o  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            ws_fwd_valid_o[i] = (CW'(i) < count_q) && gr_we_q[slot] && (dest_q[slot] != '0);
            ws_fwd_dest_o[i*RF_AW +: RF_AW] = dest_q[slot];
            ws_fwd_data_o[i*XLEN +: XLEN]   = result_q[slot];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            gr_we_q[tail_q]    <= ms_gr_we_i;
            dest_q[tail_q]     <= ms_dest_i;
            result_q[tail_q]   <= ms_result_i;
            pc_q[tail_q]       <= ms_pc_i;
            exc_q[tail_q]      <= ms_exc_i;
            exc_code_q[tail_q] <= ms_exc_code_i;
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: streaming, stalls, dest-0, exception flush,
// pointer wrap and reset with pending entries.
module tb_wb_retire_stage;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic [31:0] ms_pc;
    logic        ms_exc;
    logic [5:0]  ms_exc_code;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_flush;
    logic [31:0] ws_epc;
    logic [5:0]  ws_exc_code;
    logic [1:0]  ws_fwd_valid;
    logic [9:0]  ws_fwd_dest;
    logic [63:0] ws_fwd_data;
    logic [1:0]  ws_count;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] wlog[$];

    wb_retire_stage #(
        .XLEN (32),
        .RF_AW(5),
        .DEPTH(2),
        .EXC_W(6)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ms_to_ws_valid_i   (ms_to_ws_valid),
        .ws_allowin_o       (ws_allowin),
        .ms_gr_we_i         (ms_gr_we),
        .ms_dest_i          (ms_dest),
        .ms_result_i        (ms_result),
        .ms_pc_i            (ms_pc),
        .ms_exc_i           (ms_exc),
        .ms_exc_code_i      (ms_exc_code),
        .rf_ready_i         (rf_ready),
        .rf_we_o            (rf_we),
        .rf_waddr_o         (rf_waddr),
        .rf_wdata_o         (rf_wdata),
        .ws_flush_o         (ws_flush),
        .ws_epc_o           (ws_epc),
        .ws_exc_code_o      (ws_exc_code),
        .ws_fwd_valid_o     (ws_fwd_valid),
        .ws_fwd_dest_o      (ws_fwd_dest),
        .ws_fwd_data_o      (ws_fwd_data),
        .ws_count_o         (ws_count),
        .debug_wb_pc_o      (debug_wb_pc),
        .debug_wb_rf_we_o   (debug_wb_rf_we),
        .debug_wb_rf_wnum_o (debug_wb_rf_wnum),
        .debug_wb_rf_wdata_o(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so negedge sees the settled cycle.
    always @(negedge clk) begin
        if (!reset && rf_we && rf_ready) wlog.push_back({27'd0, rf_waddr, rf_wdata});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic g, input logic [4:0] d, input logic [31:0] r,
                         input logic [31:0] p, input logic e, input logic [5:0] c);
        ms_to_ws_valid = v;
        ms_gr_we       = g;
        ms_dest        = d;
        ms_result      = r;
        ms_pc          = p;
        ms_exc         = e;
        ms_exc_code    = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 6'd0);
    endtask

    // Offers n writing instrs (dest 8+k, result 0x200+k); model tracks occupancy.
    // mode 0: rf_ready low for cycles 0..4; mode 1: rf_ready low every third cycle.
    task automatic run_stream(input int n, input int ncyc, input int mode);
        int  idx;
        int  mcnt;
        bit  acc;
        bit  pp;
        idx  = 0;
        mcnt = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            rf_ready = (mode == 0) ? (cyc >= 5) : ((cyc % 3) != 1);
            if (idx < n) drive(1'b1, 1'b1, 5'(8 + idx), 32'h200 + 32'(idx),
                               32'h300 + 32'(4 * idx), 1'b0, 6'd0);
            else idle();
            #2;
            acc = (idx < n) && (mcnt < 2);
            pp  = (mcnt > 0) && rf_ready;
            check_eq("st_count", 64'(ws_count), 64'(mcnt));
            check_eq("st_allowin", 64'(ws_allowin), 64'(mcnt < 2));
            if (mode == 0 && cyc == 2) begin
                check_eq("st_fwd_valid", 64'(ws_fwd_valid), 64'h3);
                check_eq("st_fwd_dest", 64'(ws_fwd_dest), 64'({5'd9, 5'd8}));
                check_eq("st_fwd_data1", 64'(ws_fwd_data[63:32]), 64'h201);
                check_eq("st_dbg_we_stall", 64'(debug_wb_rf_we), 64'h0);
            end
            if (mode == 0 && cyc == 5) check_eq("st_full_pop_we", 64'(rf_we), 64'h1);
            tick();
            if (acc) idx++;
            mcnt = mcnt + int'(acc) - int'(pp);
        end
        check_eq("st_nwrites", 64'(wlog.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            check_eq("st_order", (k < wlog.size()) ? wlog[k] : 64'hx,
                     {27'd0, 5'(8 + k), 32'h200 + 32'(k)});
        end
    endtask

    initial begin
        reset    = 1'b1;
        rf_ready = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_eq("rst_count", 64'(ws_count), 64'h0);
        check_eq("rst_allowin", 64'(ws_allowin), 64'h1);
        check_eq("rst_rf_we", 64'(rf_we), 64'h0);
        check_eq("rst_flush", 64'(ws_flush), 64'h0);
        check_eq("rst_fwd_valid", 64'(ws_fwd_valid), 64'h0);
        check_eq("rst_dbg_we", 64'(debug_wb_rf_we), 64'h0);
        tick();

        // Back-to-back stream with free RF port
        wlog.delete();
        rf_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 32'h100 + 32'(4 * i),
                             1'b0, 6'd0);
            else idle();
            #2;
            check_eq("bb_allowin", 64'(ws_allowin), 64'h1);
            check_eq("bb_count", 64'(ws_count), 64'(i > 0));
            if (i > 0) begin
                check_eq("bb_rf_we", 64'(rf_we), 64'h1);
                check_eq("bb_waddr", 64'(rf_waddr), 64'(i));
                check_eq("bb_wdata", 64'(rf_wdata), 64'hA0 + 64'(i - 1));
                check_eq("bb_dbg_pc", 64'(debug_wb_pc), 64'h100 + 64'(4 * (i - 1)));
                check_eq("bb_dbg_we", 64'(debug_wb_rf_we), 64'hF);
            end
            tick();
        end
        #2;
        check_eq("bb_count_end", 64'(ws_count), 64'h0);
        check_eq("bb_nwrites", 64'(wlog.size()), 64'h4);
        tick();

        // Stall: rf_ready low 5 cycles, 4 writers offered
        wlog.delete();
        run_stream(4, 10, 0);

        // dest 0 retires without RF write while stalled
        wlog.delete();
        rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h400, 1'b0, 6'd0);
        tick();
        idle();
        #2;
        check_eq("d0_count", 64'(ws_count), 64'h1);
        check_eq("d0_rf_we", 64'(rf_we), 64'h0);
        check_eq("d0_dbg_we", 64'(debug_wb_rf_we), 64'h0);
        check_eq("d0_dbg_pc", 64'(debug_wb_pc), 64'h400);
        check_eq("d0_fwd_valid", 64'(ws_fwd_valid), 64'h0);
        tick();
        #2;
        check_eq("d0_count_after", 64'(ws_count), 64'h0);
        check_eq("d0_nwrites", 64'(wlog.size()), 64'h0);
        tick();

        // Exception behind a stalled writer; younger offers must never write
        wlog.delete();
        rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd7, 32'h77, 32'h1BFF_FFFC, 1'b0, 6'd0);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h33, 32'h1C00_0000, 1'b1, 6'h08);
        tick();
        drive(1'b1, 1'b1, 5'd5, 32'h55, 32'h1C00_0004, 1'b0, 6'd0);
        rf_ready = 1'b1;
        #2;
        check_eq("ex_count_full", 64'(ws_count), 64'h2);
        check_eq("ex_allowin_full", 64'(ws_allowin), 64'h0);
        check_eq("ex_flush_early", 64'(ws_flush), 64'h0);
        tick();
        drive(1'b1, 1'b1, 5'd6, 32'h66, 32'h1C00_0008, 1'b0, 6'd0);
        #2;
        check_eq("ex_flush", 64'(ws_flush), 64'h1);
        check_eq("ex_epc", 64'(ws_epc), 64'h1C00_0000);
        check_eq("ex_code", 64'(ws_exc_code), 64'h08);
        check_eq("ex_rf_we", 64'(rf_we), 64'h0);
        check_eq("ex_dbg_we", 64'(debug_wb_rf_we), 64'h0);
        tick();
        idle();
        #2;
        check_eq("ex_count_after", 64'(ws_count), 64'h0);
        check_eq("ex_flush_after", 64'(ws_flush), 64'h0);
        tick();
        tick();
        check_eq("ex_nwrites", 64'(wlog.size()), 64'h1);
        check_eq("ex_write0", (wlog.size() > 0) ? wlog[0] : 64'hx, {27'd0, 5'd7, 32'h77});

        // Pointer wrap with full-plus-pop cycles
        wlog.delete();
        run_stream(12, 30, 1);

        // Reset with two entries pending
        wlog.delete();
        rf_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd20, 32'hC0, 32'h500, 1'b0, 6'd0);
        tick();
        drive(1'b1, 1'b1, 5'd21, 32'hC1, 32'h504, 1'b0, 6'd0);
        tick();
        idle();
        #2;
        check_eq("rs_count_pend", 64'(ws_count), 64'h2);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        rf_ready = 1'b1;
        #2;
        check_eq("rs_count", 64'(ws_count), 64'h0);
        check_eq("rs_rf_we", 64'(rf_we), 64'h0);
        check_eq("rs_waddr", 64'(rf_waddr), 64'h0);
        check_eq("rs_fwd_valid", 64'(ws_fwd_valid), 64'h0);
        check_eq("rs_dbg_we", 64'(debug_wb_rf_we), 64'h0);
        check_eq("rs_dbg_pc", 64'(debug_wb_pc), 64'h0);
        check_eq("rs_allowin", 64'(ws_allowin), 64'h1);
        tick();
        tick();
        check_eq("rs_nwrites", 64'(wlog.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
